// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Shared types and encodings for the multi-cycle RV32I control
//            path: FSM state enum, opcode values, immediate-format codes,
//            ALU operation codes and datapath mux-select encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALRADR  = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate generator formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Memory address select
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Immediate format for a given opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:         imm = IMM_S;
      OP_LUI, OP_AUIPC: imm = IMM_U;
      OP_BRANCH:        imm = IMM_B;
      OP_JAL:           imm = IMM_J;
      default:          imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_if
// Purpose  : Bundle between the multi-cycle controller and its datapath.
//            Instruction fields, ALU flag and memory handshake flow into the
//            controller; strobes, mux selects and status flow out.
// Modports : master - controller side (decodes fields, drives strobes)
//            slave  - datapath side (supplies fields, consumes strobes)
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;

  // Datapath -> controller
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  // Controller -> datapath
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Maps the controller's ALU operation class and the funct fields
//            to an ALU operation code; flags funct3 values the core does not
//            implement (shifts and sltu).
// Ports    : aluop[1:0]  in  - add / sub / funct-decoded
//            funct3[2:0] in  - instruction[14:12]
//            funct7b5    in  - instruction[30]
//            op5         in  - instruction[5] (1 = register form)
//            alucontrol  out - ALU operation code
//            unsupported out - funct3 is 001, 011 or 101
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  wire logic [1:0] aluop,
  input  wire logic [2:0] funct3,
  input  wire logic       funct7b5,
  input  wire logic       op5,
  output logic      [2:0] alucontrol,
  output logic            unsupported
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 selects sub only for the register form; for addi it
          // is just an immediate bit.
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b100:  alucontrol = ALU_XOR;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

  // Independent of aluop so the controller can use it while still in
  // DECODE, before it commits to an execute state.
  assign unsupported = (funct3 == 3'b001) || (funct3 == 3'b011) ||
                       (funct3 == 3'b101);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore-style control FSM for the multi-cycle RV32I datapath.
//            Sequences fetch/decode/execute/writeback, produces per-cycle
//            strobes and mux selects, waits on the memory handshake and
//            parks in TRAP on unsupported encodings until reset.
// Ports    : clk   in - rising-edge clock
//            reset in - asynchronous active-high reset, forces FETCH
//            bus   master modport of multicycle_controller_if:
//              in : op, funct3, funct7b5, Zero, mem_ready
//              out: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
//                   ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              reset,
  multicycle_controller_if.master bus
);

  state_t     r_state;
  state_t     w_next;

  logic       w_pcwrite;
  logic       w_adrsrc;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic [1:0] w_resultsrc;
  logic [1:0] w_srca;
  logic [1:0] w_srcb;
  logic [1:0] w_aluop;
  logic [2:0] w_alucontrol;
  logic       w_unsup;

  alu_decoder u_alu_decoder (
    .aluop       (w_aluop),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alucontrol  (w_alucontrol),
    .unsupported (w_unsup)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-state datapath controls
  always_comb begin
    w_next      = r_state;
    w_pcwrite   = 1'b0;
    w_adrsrc    = ADR_PC;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_resultsrc = RES_ALUOUT;
    w_srca      = SRCA_PC;
    w_srcb      = SRCB_RS2;
    w_aluop     = ALUOP_ADD;

    case (r_state)
      S_FETCH: begin
        // PC+4 goes straight to the PC through ResultSrc=ALUResult while
        // the instruction is latched into IR.
        w_adrsrc    = ADR_PC;
        w_srca      = SRCA_PC;
        w_srcb      = SRCB_FOUR;
        w_resultsrc = RES_ALURESULT;
        w_irwrite   = bus.mem_ready;
        w_pcwrite   = bus.mem_ready;
        if (bus.mem_ready) begin
          w_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // OldPC + imm precomputes the branch/JAL target into ALUOut.
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = w_unsup ? S_TRAP : S_EXECR;
          OP_IMM:            w_next = w_unsup ? S_TRAP : S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALRADR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        w_srca = SRCA_RS1;
        w_srcb = SRCB_IMM;
        // op[5] separates store (0100011) from load (0000011)
        w_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        w_adrsrc    = ADR_RESULT;
        w_resultsrc = RES_ALUOUT;
        if (bus.mem_ready) begin
          w_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        w_resultsrc = RES_RDATA;
        w_regwrite  = 1'b1;
        w_next      = S_FETCH;
      end

      S_MEMWRITE: begin
        // Strobe stays up for the whole stall so the memory sees a stable
        // request until it acknowledges.
        w_adrsrc    = ADR_RESULT;
        w_resultsrc = RES_ALUOUT;
        w_memwrite  = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_FETCH;
        end
      end

      S_EXECR: begin
        w_srca  = SRCA_RS1;
        w_srcb  = SRCB_RS2;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end

      S_EXECI: begin
        w_srca  = SRCA_RS1;
        w_srcb  = SRCB_IMM;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end

      S_ALUWB: begin
        w_resultsrc = RES_ALUOUT;
        w_regwrite  = 1'b1;
        w_next      = S_FETCH;
      end

      S_BRANCH: begin
        // rs1-rs2 drives Zero; target from DECODE sits in ALUOut.
        w_srca      = SRCA_RS1;
        w_srcb      = SRCB_RS2;
        w_aluop     = ALUOP_SUB;
        w_resultsrc = RES_ALUOUT;
        w_pcwrite   = ((bus.funct3 == 3'b000) &  bus.Zero) |
                      ((bus.funct3 == 3'b001) & ~bus.Zero);
        w_next      = S_FETCH;
      end

      S_JALRADR: begin
        // rs1 + imm lands in ALUOut, then JAL loads it into the PC.
        w_srca = SRCA_RS1;
        w_srcb = SRCB_IMM;
        w_next = S_JAL;
      end

      S_JAL: begin
        // PC <- ALUOut (target) while ALU forms OldPC+4 for the link.
        w_srca      = SRCA_OLDPC;
        w_srcb      = SRCB_FOUR;
        w_resultsrc = RES_ALUOUT;
        w_pcwrite   = 1'b1;
        w_next      = S_ALUWB;
      end

      S_LUI: begin
        w_srca = SRCA_ZERO;
        w_srcb = SRCB_IMM;
        w_next = S_ALUWB;
      end

      S_AUIPC: begin
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        w_next = S_ALUWB;
      end

      S_TRAP: begin
        w_next = S_TRAP;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Strobes are gated by reset so nothing fires while reset is held, even
  // though the state register already reads FETCH.
  assign bus.PCWrite    = w_pcwrite  & ~reset;
  assign bus.IRWrite    = w_irwrite  & ~reset;
  assign bus.MemWrite   = w_memwrite & ~reset;
  assign bus.RegWrite   = w_regwrite & ~reset;
  assign bus.AdrSrc     = w_adrsrc;
  assign bus.ResultSrc  = w_resultsrc;
  assign bus.ALUSrcA    = w_srca;
  assign bus.ALUSrcB    = w_srcb;
  assign bus.ALUControl = w_alucontrol;
  assign bus.ImmSrc     = imm_src_of(bus.op);

  // Only completing states ever steer back to FETCH, so this marks the
  // last cycle of every retired instruction.
  assign bus.instr_done = (r_state != S_FETCH) && (w_next == S_FETCH) && !reset;
  assign bus.illegal    = (r_state == S_TRAP) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Self-checking bench for multicycle_controller. An instruction-
//            level model expands each instruction into its step list and
//            derives the expected control word each cycle; a compare process
//            checks the DUT on every falling edge. Directed cases pin cycle
//            counts, strobe counts and ImmSrc with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  typedef enum int {
    K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB, K_MEMWRITE, K_EXEC_R,
    K_EXEC_I, K_ALUWB, K_BRANCH, K_JALRADR, K_JAL, K_LUI, K_AUIPC, K_TRAP
  } kind_t;

  logic clk;
  logic reset;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks;
  int          failures;
  int          pcw_seen;
  int          adr_seen;
  bit          exp_valid;
  logic [18:0] exp_vec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic bit is_legal(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
      7'b0110111, 7'b0010111: return 1'b1;
      7'b0110011, 7'b0010011: return !(f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_model(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b0110111, 7'b0010111: return 3'b010;
      7'b1100011:             return 3'b101;
      7'b1101111:             return 3'b110;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] fdec(input logic op5, input logic [2:0] f3, input logic b5);
    case (f3)
      3'd0:    return (op5 && b5) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd4:    return 3'b100;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit is_wait(input kind_t k);
    return (k == K_FETCH) || (k == K_MEMREAD) || (k == K_MEMWRITE);
  endfunction

  // Packed order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc
  //               ALUSrcA ALUSrcB ALUControl ImmSrc instr_done illegal
  function automatic logic [18:0] expv(input kind_t k, input logic [6:0] o,
                                       input logic [2:0] f3, input logic b5,
                                       input logic z, input logic mr,
                                       input logic done);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (k)
      K_FETCH:    begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      K_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      K_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      K_MEMREAD:  begin adr = 1; end
      K_MEMWB:    begin res = 2'b01; rw = 1; end
      K_MEMWRITE: begin adr = 1; mw = 1; end
      K_EXEC_R:   begin sa = 2'b10; sb = 2'b00; alu = fdec(o[5], f3, b5); end
      K_EXEC_I:   begin sa = 2'b10; sb = 2'b01; alu = fdec(o[5], f3, b5); end
      K_ALUWB:    begin rw = 1; end
      K_BRANCH:   begin sa = 2'b10; alu = 3'b001;
                        pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); end
      K_JALRADR:  begin sa = 2'b10; sb = 2'b01; end
      K_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      K_LUI:      begin sa = 2'b11; sb = 2'b01; end
      K_AUIPC:    begin sa = 2'b01; sb = 2'b01; end
      default:    begin ill = 1; end
    endcase
    return {pcw, adr, mw, irw, rw, res, sa, sb, alu, imm_model(o), done, ill};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_valid) begin
      logic [18:0] act;
      act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
             bus.ImmSrc, bus.instr_done, bus.illegal};
      checks++;
      if (act !== exp_vec) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t op=%b f3=%0d act=%h exp=%h",
                 $time, bus.op, bus.funct3, act, exp_vec);
      end
      pcw_seen += int'(bus.PCWrite);
      adr_seen += int'(bus.AdrSrc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Runs one instruction from its FETCH. stall<0: random mem_ready,
  // otherwise mem_ready is held low 'stall' cycles in each data-memory wait.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic b5, input int stall, input int zmode,
                           input int trap_len, output int ncyc);
    kind_t path[$];
    kind_t k;
    int    idx, waitcnt, trapcnt;
    logic  mr, z;
    bit    last, adv;
    path = {K_FETCH, K_DECODE};
    if (!is_legal(o, f3)) path.push_back(K_TRAP);
    else case (o)
      7'b0000011: path = {path, K_MEMADR, K_MEMREAD, K_MEMWB};
      7'b0100011: path = {path, K_MEMADR, K_MEMWRITE};
      7'b0110011: path = {path, K_EXEC_R, K_ALUWB};
      7'b0010011: path = {path, K_EXEC_I, K_ALUWB};
      7'b1100011: path = {path, K_BRANCH};
      7'b1101111: path = {path, K_JAL, K_ALUWB};
      7'b1100111: path = {path, K_JALRADR, K_JAL, K_ALUWB};
      7'b0110111: path = {path, K_LUI, K_ALUWB};
      default:    path = {path, K_AUIPC, K_ALUWB};
    endcase
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = b5;
    idx = 0; ncyc = 0; waitcnt = 0; trapcnt = 0;
    while (idx < path.size()) begin
      k = path[idx];
      last = (idx == path.size() - 1) && (k != K_TRAP);
      if (stall < 0)                              mr = ($urandom_range(0, 3) != 0);
      else if (k == K_MEMREAD || k == K_MEMWRITE) mr = (waitcnt >= stall);
      else if (k == K_FETCH)                      mr = 1'b1;
      else                                        mr = 1'($urandom_range(0, 1));
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.mem_ready = mr;
      bus.Zero = z;
      adv = !(is_wait(k) && !mr);
      exp_vec = expv(k, o, f3, b5, z, mr, last && adv);
      exp_valid = 1'b1;
      @(posedge clk); #1;
      ncyc++;
      if (is_wait(k) && !mr) waitcnt++;
      if (k == K_TRAP) begin
        trapcnt++;
        if (trapcnt >= trap_len) break;
      end else if (adv) begin
        idx++;
      end
      if (ncyc > 500) begin
        failures++;
        $display("FAIL instr_timeout act=%0d exp<=500", ncyc);
        break;
      end
    end
  endtask

  // Asserted at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    exp_valid = 1'b0;
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_quiet_async", int'({bus.PCWrite, bus.IRWrite, bus.MemWrite,
          bus.RegWrite, bus.instr_done, bus.illegal}), 0);
    @(posedge clk); #1;
    check("rst_quiet_held", int'({bus.PCWrite, bus.IRWrite, bus.MemWrite,
          bus.RegWrite, bus.instr_done, bus.illegal}), 0);
    reset = 1'b0;
  endtask

  initial begin
    int n, p0, a0, sel;
    logic [6:0] ops [12];
    checks = 0; failures = 0; pcw_seen = 0; adr_seen = 0;
    exp_valid = 1'b0; exp_vec = '0;
    reset = 1'b1;
    bus.op = 7'b0110011; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_init_quiet", int'({bus.PCWrite, bus.IRWrite, bus.MemWrite,
          bus.RegWrite, bus.instr_done, bus.illegal}), 0);
    reset = 1'b0;

    // add x3,x1,x2
    run_instr(7'b0110011, 3'd0, 1'b0, 0, -1, 0, n);
    check("add_cycles", n, 4);
    check("add_imm", int'(bus.ImmSrc), 0);
    // sub
    run_instr(7'b0110011, 3'd0, 1'b1, 0, -1, 0, n);
    // lw, 3 stall cycles in MEMREAD
    a0 = adr_seen;
    run_instr(7'b0000011, 3'd2, 1'b0, 3, -1, 0, n);
    check("lw_cycles", n, 8);
    check("lw_adrsrc_cycles", adr_seen - a0, 4);
    // sw, no stall
    run_instr(7'b0100011, 3'd2, 1'b0, 0, -1, 0, n);
    check("sw_cycles", n, 4);
    check("sw_imm", int'(bus.ImmSrc), 1);
    // branches: PCWrite count includes the FETCH write
    p0 = pcw_seen; run_instr(7'b1100011, 3'd0, 1'b0, 0, 1, 0, n);
    check("beq_taken_pcw", pcw_seen - p0, 2);
    check("beq_cycles", n, 3);
    check("beq_imm", int'(bus.ImmSrc), 5);
    p0 = pcw_seen; run_instr(7'b1100011, 3'd0, 1'b0, 0, 0, 0, n);
    check("beq_nt_pcw", pcw_seen - p0, 1);
    p0 = pcw_seen; run_instr(7'b1100011, 3'd1, 1'b0, 0, 0, 0, n);
    check("bne_taken_pcw", pcw_seen - p0, 2);
    p0 = pcw_seen; run_instr(7'b1100011, 3'd1, 1'b0, 0, 1, 0, n);
    check("bne_nt_pcw", pcw_seen - p0, 1);
    p0 = pcw_seen; run_instr(7'b1100011, 3'd4, 1'b0, 0, 1, 0, n);
    check("blt_never_pcw", pcw_seen - p0, 1);
    // jalr / jal / lui
    p0 = pcw_seen; run_instr(7'b1100111, 3'd0, 1'b0, 0, -1, 0, n);
    check("jalr_cycles", n, 5);
    check("jalr_pcw", pcw_seen - p0, 2);
    check("jalr_imm", int'(bus.ImmSrc), 0);
    run_instr(7'b1101111, 3'd0, 1'b0, 0, -1, 0, n);
    check("jal_cycles", n, 4);
    check("jal_imm", int'(bus.ImmSrc), 6);
    run_instr(7'b0110111, 3'd0, 1'b0, 0, -1, 0, n);
    check("lui_imm", int'(bus.ImmSrc), 2);
    // illegal encodings
    run_instr(7'b0001111, 3'd0, 1'b0, 0, -1, 20, n);
    check("fence_trap_cycles", n, 22);
    check("fence_illegal", int'(bus.illegal), 1);
    do_reset();
    run_instr(7'b0010011, 3'd1, 1'b0, 0, -1, 20, n);
    check("slli_illegal", int'(bus.illegal), 1);
    do_reset();

    // reset during a MEMWRITE stall
    exp_valid = 1'b0;
    bus.op = 7'b0100011; bus.funct3 = 3'd2; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    #1;
    check("sw_stall_mw", int'(bus.MemWrite), 1);
    @(posedge clk); #1;
    check("sw_stall_mw_held", int'(bus.MemWrite), 1);
    check("sw_stall_adr_held", int'(bus.AdrSrc), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_mw", int'(bus.MemWrite), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(7'b0010011, 3'd7, 1'b0, 0, -1, 0, n);
    check("after_rst_cycles", n, 4);

    // randomized instruction stream
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
            7'b1110011, 7'b0000000};
    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      logic [2:0] f3;
      sel = $urandom_range(0, 11);
      o = (sel == 11) ? 7'($urandom) : ops[sel];
      f3 = 3'($urandom);
      run_instr(o, f3, 1'($urandom), -1, -1, $urandom_range(1, 4), n);
      if (!is_legal(o, f3)) do_reset();
    end

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
